risc_control_unit: RTL and testbench
====================================

RISC_CONTROL_UNIT -- requirements
Module: risc_control_unit

Interface
REQ-001 The block SHALL have parameter word_size, default 8, meaning the instruction width.
REQ-002 The block SHALL have parameter op_size, default 4, meaning the opcode width (instruction[7:4]).
REQ-003 The block SHALL have parameters Sel1_size, default 3, and Sel2_size, default 2, meaning the Bus_1 and Bus_2 mux select widths.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port instruction, input, word_size: IR contents; [7:4] opcode, [3:2] src register, [1:0] dest register.
REQ-007 The block SHALL have port Zflag, input, 1 bit: registered ALU zero flag.
REQ-008 The block SHALL have ports Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y and Load_Reg_Z, each output, 1 bit, each a register load or increment strobe.
REQ-009 The block SHALL have port Sel_Bus_1_Mux, output, Sel1_size: 0-3 selects R0-R3 and 4 selects PC.
REQ-010 The block SHALL have port Sel_Bus_2_Mux, output, Sel2_size: 0 selects alu_out, 1 selects Bus_1, 2 selects mem_word.
REQ-011 The block SHALL have port write, output, 1 bit: memory write strobe (address = Add_R, data = Bus_1).
REQ-012 The block SHALL have port halted, output, 1 bit: high while in S_halt.

Function
REQ-013 The block SHALL be a Moore/Mealy FSM with states S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt; outputs are combinational from state, opcode, src, dest and Zflag.
REQ-014 All outputs SHALL be 0 in any state or condition not listed below.
REQ-015 In S_idle, the block SHALL drive no outputs and go to S_fet1.
REQ-016 In S_fet1, the block SHALL drive Sel1=4, Sel2=1, Load_Add_R, and go to S_fet2.
REQ-017 In S_fet2, the block SHALL drive Sel2=2, Load_IR, Inc_PC, and go to S_dec.
REQ-018 In S_dec, for NOP (0), the block SHALL go to S_fet1.
REQ-019 In S_dec, for ADD (1), SUB (2) and AND (3), the block SHALL drive Sel1=src, Sel2=1, Load_Reg_Y, and go to S_ex1.
REQ-020 In S_dec, for NOT (4), the block SHALL drive Sel1=src, Sel2=0, Load_Reg_Z, Load_R[dest], and go to S_fet1.
REQ-021 In S_dec, for RD (5), WR (6), BR (7), and for BRZ (8) with Zflag=1, the block SHALL drive Sel1=4, Sel2=1, Load_Add_R, and go to S_rd1, S_wr1, S_br1 and S_br1 respectively.
REQ-022 In S_dec, for BRZ with Zflag=0, the block SHALL drive Inc_PC to skip the address byte, and go to S_fet1.
REQ-023 In S_dec, for opcodes 9-15, the block SHALL go to S_halt.
REQ-024 In S_ex1, the block SHALL drive Sel1=dest, Sel2=0, Load_Reg_Z, Load_R[dest], and go to S_fet1.
REQ-025 In S_rd1 and S_wr1, the block SHALL drive Sel2=2, Load_Add_R, Inc_PC, and go to S_rd2 or S_wr2 respectively.
REQ-026 In S_rd2, the block SHALL drive Sel2=2, Load_R[dest], and go to S_fet1.
REQ-027 In S_wr2, the block SHALL drive Sel1=src, write=1, and go to S_fet1.
REQ-028 In S_br1, the block SHALL drive Sel2=2, Load_Add_R, and go to S_br2.
REQ-029 In S_br2, the block SHALL drive Sel2=2, Load_PC, and go to S_fet1.
REQ-030 In S_halt, the block SHALL hold halted=1 with all strobes 0, and exit only via reset.
REQ-031 At most one of Load_R0-Load_R3 SHALL be high in any cycle, and Load_PC and Inc_PC SHALL never be high together.
REQ-032 Instruction latency SHALL be: NOP 3 cycles, NOT 3, ALU 4, BRZ-not-taken 3, RD/WR/BR/BRZ-taken 5 (fetch included).

Reset
REQ-033 When rst=0, the block SHALL immediately force state to S_idle, all strobes to 0, Sel1=0, Sel2=0 and halted=0, regardless of clk, including mid-instruction.
REQ-034 The first rising clk edge after rst returns high SHALL move the FSM to S_fet1.

Structure
REQ-035 Opcode constants, state encodings and select codes SHALL reside in the shared package risc_pkg.
REQ-036 The block SHALL use no sub-modules: one state register plus next-state/output logic.

Verification
REQ-037 The bench SHALL drive reset, then instruction=0x00 (NOP): the state sequence SHALL be idle, fet1, fet2, dec, fet1, with Inc_PC high in fet2 only.
REQ-038 The bench SHALL drive instruction=0x16 (ADD R1,R2): in dec, Sel1=1 and Load_Reg_Y=1; in ex1, Sel1=2, Sel2=0, Load_R2=1 and Load_Reg_Z=1.
REQ-039 The bench SHALL drive instruction=0x5B (RD to R3): in rd1, Load_Add_R=1 and Inc_PC=1; in rd2, Sel2=2 and Load_R3=1.
REQ-040 The bench SHALL drive instruction=0x80 with Zflag=0, then with Zflag=1: in the first case Inc_PC pulses in dec and the FSM returns to fet1; in the second case Load_PC=1 in br2.
REQ-041 The bench SHALL drive instruction=0xF0: halted SHALL go to 1 and stay for 20 cycles; asserting rst low SHALL clear it asynchronously.
REQ-042 The bench SHALL assert rst low during wr2 of instruction=0x6C: write SHALL drop to 0 at once, and fetch SHALL restart after release.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC control unit: FSM state encoding,
// opcode constants and the Bus_1 / Bus_2 mux select codes.
package risc_pkg;

  typedef enum logic [3:0] {
    S_idle = 4'd0,
    S_fet1 = 4'd1,
    S_fet2 = 4'd2,
    S_dec  = 4'd3,
    S_ex1  = 4'd4,
    S_rd1  = 4'd5,
    S_rd2  = 4'd6,
    S_wr1  = 4'd7,
    S_wr2  = 4'd8,
    S_br1  = 4'd9,
    S_br2  = 4'd10,
    S_halt = 4'd11
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  // Bus_1 mux: codes 0-3 pick R0-R3 directly, 4 picks the PC.
  localparam logic [2:0] SEL1_PC   = 3'd4;

  // Bus_2 mux.
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

endpackage

// File: rtl/risc_control_unit_if.sv
// Control bundle between the control unit and the datapath.
//   instruction / Zflag       : datapath -> control (IR contents, zero flag)
//   Load_* / Inc_PC / write   : control -> datapath strobes
//   Sel_Bus_1_Mux / _2_Mux    : control -> datapath mux selects
//   halted                    : high while the FSM sits in S_halt
//   state                     : FSM state, exported for observation
// Modport master is the control unit, slave is the datapath side.
// There is no valid/ready handshake here: every strobe is a single-cycle
// qualifier that the datapath acts on at the next rising clk edge.
interface risc_control_unit_if
  import risc_pkg::*;
#(
  parameter int word_size = 8,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 2
) ();

  logic [word_size-1:0] instruction;
  logic                 Zflag;
  logic                 Load_R0;
  logic                 Load_R1;
  logic                 Load_R2;
  logic                 Load_R3;
  logic                 Load_PC;
  logic                 Inc_PC;
  logic                 Load_IR;
  logic                 Load_Add_R;
  logic                 Load_Reg_Y;
  logic                 Load_Reg_Z;
  logic [Sel1_size-1:0] Sel_Bus_1_Mux;
  logic [Sel2_size-1:0] Sel_Bus_2_Mux;
  logic                 write;
  logic                 halted;
  state_t               state;

  modport master (
    input  instruction, Zflag,
    output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
           Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux,
           write, halted, state
  );

  modport slave (
    output instruction, Zflag,
    input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
           Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux,
           write, halted, state
  );

endinterface

// File: rtl/risc_control_unit.sv
// Sequencing FSM for a small 8-bit RISC datapath. Fetches through Add_R/IR,
// decodes the opcode and issues register/memory strobes per instruction.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (forces S_idle, all outputs 0)
//   bus : risc_control_unit_if.master (instruction/Zflag in, strobes out)
// Outputs are decoded combinationally from the state register, so reset
// clears them immediately without waiting for a clock edge.
module risc_control_unit
  import risc_pkg::*;
#(
  parameter int word_size = 8,
  parameter int op_size   = 4,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 2
) (
  input  logic                clk,
  input  logic                rst,
  risc_control_unit_if.master bus
);

  state_t state_q, state_d;

  logic [op_size-1:0]   opcode;
  logic [1:0]           src;
  logic [1:0]           dest;
  logic [3:0]           load_r;
  logic                 load_pc, inc_pc, load_ir, load_add_r;
  logic                 load_reg_y, load_reg_z, write_s, halted_s;
  logic [Sel1_size-1:0] sel1;
  logic [Sel2_size-1:0] sel2;

  assign opcode = bus.instruction[word_size-1 -: op_size];
  assign src    = bus.instruction[3:2];
  assign dest   = bus.instruction[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_idle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_r     = '0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write_s    = 1'b0;
    halted_s   = 1'b0;
    sel1       = '0;
    sel2       = '0;
    case (state_q)
      S_idle: state_d = S_fet1;
      S_fet1: begin
        sel1       = Sel1_size'(SEL1_PC);
        sel2       = Sel2_size'(SEL2_BUS1);
        load_add_r = 1'b1;
        state_d    = S_fet2;
      end
      S_fet2: begin
        sel2    = Sel2_size'(SEL2_MEM);
        load_ir = 1'b1;
        inc_pc  = 1'b1;
        state_d = S_dec;
      end
      S_dec: begin
        case (opcode)
          op_size'(OP_NOP): state_d = S_fet1;
          op_size'(OP_ADD), op_size'(OP_SUB), op_size'(OP_AND): begin
            sel1       = Sel1_size'(src);
            sel2       = Sel2_size'(SEL2_BUS1);
            load_reg_y = 1'b1;
            state_d    = S_ex1;
          end
          op_size'(OP_NOT): begin
            sel1         = Sel1_size'(src);
            sel2         = Sel2_size'(SEL2_ALU);
            load_reg_z   = 1'b1;
            load_r[dest] = 1'b1;
            state_d      = S_fet1;
          end
          op_size'(OP_RD), op_size'(OP_WR), op_size'(OP_BR): begin
            // PC points at the address byte; latch it into Add_R.
            sel1       = Sel1_size'(SEL1_PC);
            sel2       = Sel2_size'(SEL2_BUS1);
            load_add_r = 1'b1;
            if (opcode == op_size'(OP_RD))      state_d = S_rd1;
            else if (opcode == op_size'(OP_WR)) state_d = S_wr1;
            else                                state_d = S_br1;
          end
          op_size'(OP_BRZ): begin
            if (bus.Zflag) begin
              sel1       = Sel1_size'(SEL1_PC);
              sel2       = Sel2_size'(SEL2_BUS1);
              load_add_r = 1'b1;
              state_d    = S_br1;
            end else begin
              // Not taken: step the PC over the unused address byte.
              inc_pc  = 1'b1;
              state_d = S_fet1;
            end
          end
          default: state_d = S_halt;
        endcase
      end
      S_ex1: begin
        sel1         = Sel1_size'(dest);
        sel2         = Sel2_size'(SEL2_ALU);
        load_reg_z   = 1'b1;
        load_r[dest] = 1'b1;
        state_d      = S_fet1;
      end
      S_rd1, S_wr1: begin
        sel2       = Sel2_size'(SEL2_MEM);
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        state_d    = (state_q == S_rd1) ? S_rd2 : S_wr2;
      end
      S_rd2: begin
        sel2         = Sel2_size'(SEL2_MEM);
        load_r[dest] = 1'b1;
        state_d      = S_fet1;
      end
      S_wr2: begin
        sel1    = Sel1_size'(src);
        write_s = 1'b1;
        state_d = S_fet1;
      end
      S_br1: begin
        sel2       = Sel2_size'(SEL2_MEM);
        load_add_r = 1'b1;
        state_d    = S_br2;
      end
      S_br2: begin
        sel2    = Sel2_size'(SEL2_MEM);
        load_pc = 1'b1;
        state_d = S_fet1;
      end
      S_halt: halted_s = 1'b1;
      default: state_d = S_idle;
    endcase
  end

  assign bus.Load_R0       = load_r[0];
  assign bus.Load_R1       = load_r[1];
  assign bus.Load_R2       = load_r[2];
  assign bus.Load_R3       = load_r[3];
  assign bus.Load_PC       = load_pc;
  assign bus.Inc_PC        = inc_pc;
  assign bus.Load_IR       = load_ir;
  assign bus.Load_Add_R    = load_add_r;
  assign bus.Load_Reg_Y    = load_reg_y;
  assign bus.Load_Reg_Z    = load_reg_z;
  assign bus.Sel_Bus_1_Mux = sel1;
  assign bus.Sel_Bus_2_Mux = sel2;
  assign bus.write         = write_s;
  assign bus.halted        = halted_s;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_risc_control_unit.sv
module tb_risc_control_unit;
  import risc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  risc_control_unit_if #(.word_size(8), .Sel1_size(3), .Sel2_size(2)) bus ();

  risc_control_unit #(.word_size(8), .op_size(4), .Sel1_size(3), .Sel2_size(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observation vector: {state, load_r[3:0], Load_PC, Inc_PC, Load_IR,
  // Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted, Sel1[2:0], Sel2[1:0]}
  function automatic logic [20:0] act();
    return {4'(bus.state), bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0,
            bus.Load_PC, bus.Inc_PC, bus.Load_IR, bus.Load_Add_R,
            bus.Load_Reg_Y, bus.Load_Reg_Z, bus.write, bus.halted,
            bus.Sel_Bus_1_Mux, bus.Sel_Bus_2_Mux};
  endfunction

  function automatic logic [20:0] vec(input state_t st, input logic [3:0] lr,
                                      input logic ldpc, incpc, ldir, ldar,
                                      input logic ldy, ldz, wr, hl,
                                      input logic [2:0] s1, input logic [1:0] s2);
    return {4'(st), lr, ldpc, incpc, ldir, ldar, ldy, ldz, wr, hl, s1, s2};
  endfunction

  // Instruction latency in cycles, fetch included.
  function automatic int latency(input logic [7:0] ins, input logic z);
    int op;
    op = int'(ins[7:4]);
    if (op == 0 || op == 4) return 3;
    if (op >= 1 && op <= 3) return 4;
    if (op >= 5 && op <= 7) return 5;
    if (op == 8)            return z ? 5 : 3;
    return 3;
  endfunction

  // Reference: expected outputs in cycle k of an instruction (k=0 is fet1).
  function automatic logic [20:0] model(input logic [7:0] ins, input logic z, input int k);
    int         op;
    logic [1:0] src, dst;
    logic [3:0] lr_dst;
    op     = int'(ins[7:4]);
    src    = ins[3:2];
    dst    = ins[1:0];
    lr_dst = 4'b0001 << dst;
    if (k == 0) return vec(S_fet1, 4'b0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd4, 2'd1);
    if (k == 1) return vec(S_fet2, 4'b0, 0, 1, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2);
    if (k == 2) begin
      if (op >= 1 && op <= 3) return vec(S_dec, 4'b0, 0, 0, 0, 0, 1, 0, 0, 0, {1'b0, src}, 2'd1);
      if (op == 4)            return vec(S_dec, lr_dst, 0, 0, 0, 0, 0, 1, 0, 0, {1'b0, src}, 2'd0);
      if ((op >= 5 && op <= 7) || (op == 8 && z))
                              return vec(S_dec, 4'b0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd4, 2'd1);
      if (op == 8)            return vec(S_dec, 4'b0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0);
      return vec(S_dec, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0);
    end
    if (k == 3) begin
      if (op >= 1 && op <= 3) return vec(S_ex1, lr_dst, 0, 0, 0, 0, 0, 1, 0, 0, {1'b0, dst}, 2'd0);
      if (op == 5)            return vec(S_rd1, 4'b0, 0, 1, 0, 1, 0, 0, 0, 0, 3'd0, 2'd2);
      if (op == 6)            return vec(S_wr1, 4'b0, 0, 1, 0, 1, 0, 0, 0, 0, 3'd0, 2'd2);
      return vec(S_br1, 4'b0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd2);
    end
    if (op == 5) return vec(S_rd2, lr_dst, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2);
    if (op == 6) return vec(S_wr2, 4'b0, 0, 0, 0, 0, 0, 0, 1, 0, {1'b0, src}, 2'd0);
    return vec(S_br2, 4'b0, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2);
  endfunction

  // ---------------- driver ----------------
  // Entered one time unit after a rising edge; checks cycles first..last,
  // returning one time unit after the edge that ends cycle 'last'.
  task automatic run_steps(input logic [7:0] ins, input logic z, input int first, input int last);
    logic [20:0]   exp_q[$];
    logic [20:0]   got, e;
    logic [3:0]    lr;
    bus.instruction = ins;
    bus.Zflag       = z;
    for (int k = first; k <= last; k++) exp_q.push_back(model(ins, z, k));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      got = act();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL step ins=%h z=%0d: got %h expected %h", ins, z, got, e);
      end
      lr = {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0};
      checks++;
      if (!$onehot0(lr) || (bus.Load_PC && bus.Inc_PC)) begin
        errors++;
        $display("FAIL strobe_exclusive: load_r=%b pc=%b inc=%b expected onehot0/not both", lr, bus.Load_PC, bus.Inc_PC);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [7:0] ins, input logic z);
    run_steps(ins, z, 0, latency(ins, z) - 1);
    checks++;
    if (bus.state !== S_fet1) begin
      errors++;
      $display("FAIL latency ins=%h z=%0d: state %0d expected %0d", ins, z, bus.state, S_fet1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.instruction = 8'h00;
    bus.Zflag       = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++;
    if (act() !== vec(S_idle, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", act(), vec(S_idle, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0));
    end
    @(negedge clk);
    checks++;
    if (bus.state !== S_idle) begin
      errors++;
      $display("FAIL reset_hold: state %0d expected %0d", bus.state, S_idle);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.state !== S_idle) begin
      errors++;
      $display("FAIL idle_after_release: state %0d expected %0d", bus.state, S_idle);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== S_fet1) begin
      errors++;
      $display("FAIL first_edge: state %0d expected %0d", bus.state, S_fet1);
    end
  endtask

  task automatic test_nop();
    run_steps(8'h00, 1'b0, 0, 1);
    @(negedge clk);
    checks++;
    if (bus.state !== S_dec || bus.Inc_PC !== 1'b0) begin
      errors++;
      $display("FAIL nop_dec: state %0d inc %b expected %0d 0", bus.state, bus.Inc_PC, S_dec);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== S_fet1) begin
      errors++;
      $display("FAIL nop_return: state %0d expected %0d", bus.state, S_fet1);
    end
  endtask

  task automatic test_add();
    run_steps(8'h16, 1'b0, 0, 1);
    @(negedge clk);
    checks++;
    if (bus.Sel_Bus_1_Mux !== 3'd1 || bus.Load_Reg_Y !== 1'b1) begin
      errors++;
      $display("FAIL add_dec: sel1 %0d ldy %b expected 1 1", bus.Sel_Bus_1_Mux, bus.Load_Reg_Y);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.state !== S_ex1 || bus.Sel_Bus_1_Mux !== 3'd2 || bus.Sel_Bus_2_Mux !== 2'd0 ||
        bus.Load_R2 !== 1'b1 || bus.Load_Reg_Z !== 1'b1) begin
      errors++;
      $display("FAIL add_ex1: st %0d sel1 %0d sel2 %0d r2 %b z %b expected %0d 2 0 1 1",
               bus.state, bus.Sel_Bus_1_Mux, bus.Sel_Bus_2_Mux, bus.Load_R2, bus.Load_Reg_Z, S_ex1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rd();
    run_steps(8'h5B, 1'b0, 0, 2);
    @(negedge clk);
    checks++;
    if (bus.state !== S_rd1 || bus.Load_Add_R !== 1'b1 || bus.Inc_PC !== 1'b1) begin
      errors++;
      $display("FAIL rd1: st %0d ldar %b inc %b expected %0d 1 1", bus.state, bus.Load_Add_R, bus.Inc_PC, S_rd1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.state !== S_rd2 || bus.Sel_Bus_2_Mux !== 2'd2 || bus.Load_R3 !== 1'b1) begin
      errors++;
      $display("FAIL rd2: st %0d sel2 %0d r3 %b expected %0d 2 1", bus.state, bus.Sel_Bus_2_Mux, bus.Load_R3, S_rd2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_brz();
    run_steps(8'h80, 1'b0, 0, 1);
    @(negedge clk);
    checks++;
    if (bus.Inc_PC !== 1'b1) begin
      errors++;
      $display("FAIL brz_nt_inc: inc %b expected 1", bus.Inc_PC);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== S_fet1) begin
      errors++;
      $display("FAIL brz_nt_return: state %0d expected %0d", bus.state, S_fet1);
    end
    run_steps(8'h80, 1'b1, 0, 3);
    @(negedge clk);
    checks++;
    if (bus.state !== S_br2 || bus.Load_PC !== 1'b1) begin
      errors++;
      $display("FAIL brz_t_br2: st %0d ldpc %b expected %0d 1", bus.state, bus.Load_PC, S_br2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [7:0] ins;
    logic       z;
    for (int n = 0; n < 40; n++) begin
      ins = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))};
      z   = 1'($urandom_range(0, 1));
      run_instr(ins, z);
    end
  endtask

  task automatic test_reset_mid_write();
    run_steps(8'h6C, 1'b0, 0, 3);
    @(negedge clk);
    checks++;
    if (bus.state !== S_wr2 || bus.write !== 1'b1) begin
      errors++;
      $display("FAIL wr2_write: st %0d write %b expected %0d 1", bus.state, bus.write, S_wr2);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (act() !== vec(S_idle, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0)) begin
      errors++;
      $display("FAIL wr2_async_reset: got %h expected %h", act(), vec(S_idle, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0));
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== S_fet1) begin
      errors++;
      $display("FAIL wr2_restart: state %0d expected %0d", bus.state, S_fet1);
    end
    run_instr(8'h00, 1'b0);
  endtask

  task automatic test_halt();
    logic [20:0] exp_halt;
    exp_halt = vec(S_halt, 4'b0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 2'd0);
    run_steps(8'hF0, 1'b0, 0, 2);
    for (int n = 0; n < 20; n++) begin
      bus.instruction = 8'($urandom_range(0, 255));
      bus.Zflag       = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (act() !== exp_halt) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: got %h expected %h", n, act(), exp_halt);
      end
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.halted !== 1'b0 || bus.state !== S_idle) begin
      errors++;
      $display("FAIL halt_async_clear: halted %b st %0d expected 0 %0d", bus.halted, bus.state, S_idle);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== S_fet1) begin
      errors++;
      $display("FAIL halt_restart: state %0d expected %0d", bus.state, S_fet1);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_nop();
    test_add();
    test_rd();
    test_brz();
    run_instr(8'h4E, 1'b0);
    run_instr(8'h67, 1'b1);
    run_instr(8'h71, 1'b0);
    test_random();
    test_reset_mid_write();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
